// File: rtl/game_controller.sv
// game_controller: IDLE/RUNNING/OVER sequencer for the dinosaur runner.
// Decides collisions from the jump phase and obstacle position, keeps a
// 4-digit BCD score (saturating at 9999) and a high score, and enforces a
// post-game lockout before a restart is accepted.

// One BCD digit of the score incrementer; digits chain through carry.
module bcd_digit_inc (
    input  logic [3:0] digit,
    input  logic       carry_in,
    output logic [3:0] digit_next,
    output logic       carry_out
);
    assign carry_out  = carry_in & (digit == 4'd9);
    assign digit_next = !carry_in        ? digit :
                        (digit == 4'd9)  ? 4'd0  : digit + 4'd1;
endmodule

module game_controller #(
    parameter logic [9:0] DINO_X    = 10'd40,
    parameter logic [9:0] DINO_W    = 10'd16,
    parameter logic [5:0] CLEAR_MAX = 6'd56,
    parameter logic [7:0] SCORE_DIV = 8'd6,
    parameter logic [7:0] LOCKOUT   = 8'd30
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        tick,
    input  logic        button_start,
    input  logic [5:0]  jump_phase,
    input  logic        obstacle_valid,
    input  logic [9:0]  obstacle_x,
    output logic        game_status,
    output logic        game_over,
    output logic [15:0] score,
    output logic [15:0] high_score
);
    localparam int NUM_DIGITS = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    // Window bounds carried at 11 bits so DINO_X+DINO_W-1 cannot wrap.
    localparam logic [10:0] WIN_LO = {1'b0, DINO_X};
    localparam logic [10:0] WIN_HI = {1'b0, DINO_X} + {1'b0, DINO_W} - 11'd1;

    logic [1:0]  state;
    logic        start_q;
    logic [7:0]  div_cnt;
    logic [7:0]  lock_cnt;

    logic        start_edge;
    logic        in_window;
    logic        hit;
    logic        score_step;

    logic [NUM_DIGITS:0]             carry;
    logic [NUM_DIGITS-1:0][3:0]      score_digits;
    logic [NUM_DIGITS-1:0][3:0]      score_inc;
    logic                            score_at_max;

    assign start_edge = button_start & ~start_q;
    assign in_window  = ({1'b0, obstacle_x} >= WIN_LO) && ({1'b0, obstacle_x} <= WIN_HI);
    assign hit        = obstacle_valid & in_window & (jump_phase > CLEAR_MAX);
    assign score_step = (div_cnt == SCORE_DIV - 8'd1);

    // BCD incrementer: ripple carry from the least significant digit.
    // A carry out of the top digit means every digit is 9, i.e. saturated.
    assign score_digits = score;
    assign carry[0]     = 1'b1;
    assign score_at_max = carry[NUM_DIGITS];

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_digit_inc u_digit (
                .digit      (score_digits[g]),
                .carry_in   (carry[g]),
                .digit_next (score_inc[g]),
                .carry_out  (carry[g+1])
            );
        end
    endgenerate

    assign game_status = (state == ST_RUN);
    assign game_over   = (state == ST_OVER);

    // Game sequencer: state, scoring divider, lockout and high score.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            start_q    <= 1'b1;
            score      <= 16'h0000;
            high_score <= 16'h0000;
            div_cnt    <= 8'd0;
            lock_cnt   <= 8'd0;
        end else begin
            start_q <= button_start;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state   <= ST_RUN;
                        score   <= 16'h0000;
                        div_cnt <= 8'd0;
                    end
                end
                ST_RUN: begin
                    // Collision wins over a coinciding score tick.
                    if (hit) begin
                        state    <= ST_OVER;
                        lock_cnt <= LOCKOUT;
                        if (score > high_score)
                            high_score <= score;
                    end else if (tick) begin
                        if (score_step) begin
                            div_cnt <= 8'd0;
                            if (!score_at_max)
                                score <= score_inc;
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                end
                ST_OVER: begin
                    // Restart looks at the pre-decrement lock count.
                    if (start_edge && lock_cnt == 8'd0) begin
                        state   <= ST_RUN;
                        score   <= 16'h0000;
                        div_cnt <= 8'd0;
                    end
                    if (tick && lock_cnt != 8'd0)
                        lock_cnt <= lock_cnt - 8'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: a vector table, directed
// multi-cycle sequences and randomized stimulus against a points-based model.
module tb_game_controller;
    localparam int DX = 40, DW = 16, CMAX = 56, DIV = 6, LOCK = 30;
    localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;

    logic        CLK = 1'b0;
    logic        RST, tick, button_start, obstacle_valid;
    logic [5:0]  jump_phase;
    logic [9:0]  obstacle_x;
    logic        game_status, game_over;
    logic [15:0] score, high_score;

    int checks = 0;
    int failures = 0;
    bit mchk = 1'b1;

    // Reference model: score kept as an integer point count.
    int m_mode = M_IDLE, m_pts = 0, m_hi = 0, m_div = 0, m_lock = 0;
    bit m_prev = 1'b1;

    game_controller dut (
        .CLK(CLK), .RST(RST), .tick(tick), .button_start(button_start),
        .jump_phase(jump_phase), .obstacle_valid(obstacle_valid),
        .obstacle_x(obstacle_x), .game_status(game_status),
        .game_over(game_over), .score(score), .high_score(high_score)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] to_bcd(input int p);
        logic [15:0] r;
        r[15:12] = 4'((p / 1000) % 10);
        r[11:8]  = 4'((p / 100) % 10);
        r[7:4]   = 4'((p / 10) % 10);
        r[3:0]   = 4'(p % 10);
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic m_step();
        bit edge_s, hit_s;
        int ox, jp;
        ox = int'(obstacle_x);
        jp = int'(jump_phase);
        edge_s = button_start && !m_prev;
        hit_s  = obstacle_valid && ox >= DX && ox <= DX + DW - 1 && jp > CMAX;
        if (RST) begin
            m_mode = M_IDLE; m_pts = 0; m_hi = 0; m_div = 0; m_lock = 0; m_prev = 1'b1;
            return;
        end
        case (m_mode)
            M_IDLE: if (edge_s) begin m_mode = M_RUN; m_pts = 0; m_div = 0; end
            M_RUN: begin
                if (hit_s) begin
                    m_mode = M_OVER; m_lock = LOCK;
                    if (m_pts > m_hi) m_hi = m_pts;
                end else if (tick) begin
                    m_div++;
                    if (m_div == DIV) begin
                        m_div = 0;
                        if (m_pts < 9999) m_pts++;
                    end
                end
            end
            default: begin
                if (edge_s && m_lock == 0) begin m_mode = M_RUN; m_pts = 0; m_div = 0; end
                else if (tick && m_lock > 0) m_lock--;
            end
        endcase
        m_prev = button_start;
    endtask

    // One clock: advance the model on the same inputs the DUT samples.
    task automatic cyc();
        m_step();
        @(posedge CLK);
        #1;
        if (mchk) begin
            chk("model_status", game_status, (m_mode == M_RUN) ? 1'b1 : 1'b0);
            chk("model_over", game_over, (m_mode == M_OVER) ? 1'b1 : 1'b0);
            chk("model_score", score, to_bcd(m_pts));
            chk("model_high", high_score, to_bcd(m_hi));
        end
    endtask

    task automatic idle_inputs();
        tick = 1'b0; obstacle_valid = 1'b0; obstacle_x = 10'd0; jump_phase = 6'h3F;
    endtask

    task automatic do_reset();
        RST = 1'b1; button_start = 1'b0; idle_inputs();
        cyc();
        RST = 1'b0;
    endtask

    task automatic start_game();
        button_start = 1'b0; cyc();
        button_start = 1'b1; cyc();
        button_start = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        tick = 1'b0;
    endtask

    task automatic hit_now(input logic tk);
        obstacle_valid = 1'b1; obstacle_x = 10'd40; jump_phase = 6'd63; tick = tk;
        cyc();
        idle_inputs();
    endtask

    typedef struct {
        logic        rst, btn, ov;
        logic [9:0]  ox;
        logic [5:0]  jp;
        logic        e_st, e_ov;
        logic [15:0] e_sc;
    } vec_t;

    vec_t vt[13];

    initial begin
        RST = 1'b1; button_start = 1'b1; idle_inputs();

        // rst btn ov ox jp -> status over score
        vt[0]  = '{1, 1, 0, 10'd0,  6'd63, 0, 0, 16'h0};  // reset, button held
        vt[1]  = '{0, 1, 0, 10'd0,  6'd63, 0, 0, 16'h0};  // held: no edge
        vt[2]  = '{0, 0, 0, 10'd0,  6'd63, 0, 0, 16'h0};
        vt[3]  = '{0, 1, 0, 10'd0,  6'd63, 1, 0, 16'h0};  // edge -> RUNNING
        vt[4]  = '{0, 1, 1, 10'd40, 6'd56, 1, 0, 16'h0};  // clear at CLEAR_MAX
        vt[5]  = '{0, 1, 1, 10'd39, 6'd63, 1, 0, 16'h0};  // left of window
        vt[6]  = '{0, 1, 1, 10'd56, 6'd63, 1, 0, 16'h0};  // right of window
        vt[7]  = '{0, 1, 1, 10'd40, 6'd57, 0, 1, 16'h0};  // one above clear: hit
        vt[8]  = '{1, 0, 0, 10'd0,  6'd63, 0, 0, 16'h0};
        vt[9]  = '{0, 0, 0, 10'd0,  6'd63, 0, 0, 16'h0};
        vt[10] = '{0, 1, 0, 10'd0,  6'd63, 1, 0, 16'h0};
        vt[11] = '{0, 1, 1, 10'd55, 6'd63, 0, 1, 16'h0};  // last window column
        vt[12] = '{0, 0, 0, 10'd55, 6'd63, 0, 1, 16'h0};

        for (int i = 0; i < 13; i++) begin
            RST = vt[i].rst; button_start = vt[i].btn; obstacle_valid = vt[i].ov;
            obstacle_x = vt[i].ox; jump_phase = vt[i].jp; tick = 1'b0;
            cyc();
            chk($sformatf("vec%0d_status", i), game_status, vt[i].e_st);
            chk($sformatf("vec%0d_over", i), game_over, vt[i].e_ov);
            chk($sformatf("vec%0d_score", i), score, vt[i].e_sc);
        end
        RST = 1'b0;

        // Scoring with BCD carries.
        do_reset();
        start_game();
        chk("start_score", score, 16'h0000);
        ticks(60);
        chk("score_60_ticks", score, 16'h0010);
        ticks(534);
        chk("score_99", score, 16'h0099);
        ticks(6);
        chk("score_carry_100", score, 16'h0100);

        // Hit coinciding with a score-completing tick.
        do_reset();
        start_game();
        ticks(77);
        chk("pre_hit_score", score, 16'h0012);
        hit_now(1'b1);
        chk("hit_tick_over", game_over, 1'b1);
        chk("hit_tick_status", game_status, 1'b0);
        chk("hit_tick_score", score, 16'h0012);
        chk("hit_tick_high", high_score, 16'h0012);

        // Lockout.
        ticks(29);
        button_start = 1'b1; cyc();
        chk("lock_29_ignored", game_over, 1'b1);
        button_start = 1'b0; cyc();
        button_start = 1'b1; tick = 1'b1; cyc();
        tick = 1'b0;
        chk("lock_30th_tick_ignored", game_over, 1'b1);
        button_start = 1'b0; cyc();
        button_start = 1'b1; cyc();
        button_start = 1'b0;
        chk("lock_done_status", game_status, 1'b1);
        chk("lock_done_score", score, 16'h0000);

        // Lower score does not replace the high score.
        ticks(30);
        hit_now(1'b0);
        chk("second_score", score, 16'h0005);
        chk("second_high", high_score, 16'h0012);

        // Reset mid-game.
        ticks(10);
        start_game();  // still locked out: stays OVER
        chk("locked_restart", game_over, 1'b1);
        do_reset();
        start_game();
        ticks(252);
        chk("pre_reset_score", score, 16'h0042);
        RST = 1'b1; cyc(); RST = 1'b0;
        chk("midreset_status", game_status, 1'b0);
        chk("midreset_score", score, 16'h0000);
        chk("midreset_high", high_score, 16'h0000);

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) button_start = ~button_start;
            tick = 1'($urandom_range(0, 1));
            obstacle_valid = ($urandom_range(0, 7) == 0);
            obstacle_x = 10'($urandom_range(30, 65));
            jump_phase = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(50, 62)) : 6'd63;
            cyc();
        end
        RST = 1'b0;

        // Saturation at 9999.
        do_reset();
        start_game();
        mchk = 1'b0;
        ticks(9999 * DIV);
        mchk = 1'b1;
        chk("score_9999", score, 16'h9999);
        ticks(12);
        chk("score_saturated", score, 16'h9999);
        chk("sat_status", game_status, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/game_controller.md
# game_controller

Top-level game-state sequencer for the dinosaur runner. It sits directly downstream of the jump stage and consumes its 6-bit jump phase to decide whether the dinosaur clears the current obstacle. It owns the IDLE/RUNNING/OVER state machine, drives `game_status` to the jump stage and renderer, and keeps a 4-digit BCD score and a high score.

## Interface
Parameters:
- `DINO_X`, default 10'd40: leftmost obstacle column occupied by the dinosaur.
- `DINO_W`, default 10'd16: dinosaur width in columns. The hit window is `DINO_X` .. `DINO_X+DINO_W-1` inclusive.
- `CLEAR_MAX`, default 6'd56: the dinosaur is clear of obstacles when `jump_phase <= CLEAR_MAX`.
- `SCORE_DIV`, default 8'd6: number of frame ticks per score point (must be ≥1).
- `LOCKOUT`, default 8'd30: number of frame ticks after game over during which start is ignored.

Ports:
- `CLK` in 1: system clock; all logic on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle frame strobe.
- `button_start` in 1: start/restart button, already synchronized, level-sensitive.
- `jump_phase` in 6: jump-stage height counter. 6'h3F means on the ground; lower values mean airborne.
- `obstacle_valid` in 1: an obstacle is on screen.
- `obstacle_x` in 10: obstacle left column.
- `game_status` out 1: 1 while RUNNING.
- `game_over` out 1: 1 while OVER.
- `score` out 16: 4 BCD digits, `[15:12]` is the most significant digit.
- `high_score` out 16: 4 BCD digits.

## Operation
- **Start edge.** `start_edge` = `button_start & ~start_q`, where `start_q` is the registered previous value of `button_start`. `start_q` resets to 1, so a button held through reset gives no edge.
- **Hit.** `hit` = `obstacle_valid` & (`DINO_X <= obstacle_x <= DINO_X+DINO_W-1`) & (`jump_phase > CLEAR_MAX`). Comparisons are unsigned. The window sum is computed 11 bits wide, so there is no wrap.
- **State machine** (state, div_cnt, lock_cnt):
  - **IDLE.** `start_edge` → RUNNING; clear `score` and `div_cnt`.
  - **RUNNING.**
    - If `hit`, go to OVER, set `lock_cnt` = `LOCKOUT`, and set `high_score` = max(`high_score`, `score`) using BCD-ordered unsigned compare of the 16-bit value.
    - Otherwise, on `tick`: if `div_cnt == SCORE_DIV-1`, then `div_cnt` = 0 and `score` increments in BCD. Otherwise `div_cnt` increments.
    - `start_edge` is ignored.
  - **OVER.**
    - On `tick` with `lock_cnt != 0`, decrement `lock_cnt`.
    - `start_edge` with `lock_cnt == 0` → RUNNING, clearing `score` and `div_cnt`.
    - `score` holds its final value.
- **BCD increment.** Each digit rolls 9→0 with carry. The score saturates at 16'h9999 and does not wrap.
- **Simultaneous events.**
  - `hit` and a score-completing `tick` in the same cycle: the hit wins. `score` does not increment, and `high_score` compares the pre-increment score.
  - `start_edge` in the same OVER cycle where `tick` decrements `lock_cnt` from 1 to 0: the start is ignored, because the old `lock_cnt` is evaluated.
- **Reset.** Reset mid-game returns to IDLE regardless of state.
  - `game_status`=0, `game_over`=0.
  - `score`=0, `high_score`=0.
  - `div_cnt`=0, `lock_cnt`=0, `start_q`=1.

## Timing
- All outputs are registered. `game_status` and `game_over` are decoded from the state register and change on the edge after the causing input is sampled.
- Start latency: `button_start` rises in cycle N → `start_edge` in cycle N → `game_status`=1 in cycle N+1.
- Hit latency: `hit` is true in cycle N → `game_status`=0, `game_over`=1, and `high_score` are updated in cycle N+1.
- Collision is evaluated every clock, not only on `tick`.
- Score changes only on `tick` cycles. At most one increment per `tick`.

## Test plan
- **Reset and start edge.** Assert `RST` with `button_start`=1, release `RST`, keep the button held → stays IDLE, all outputs 0. Drop the button, then raise it → `game_status`=1 one cycle later, `score`=0.
- **Scoring and saturation.** RUNNING, `SCORE_DIV`=6, no obstacle, 60 ticks → `score`=16'h0010. Preload score 16'h0099 and give 6 ticks → 16'h0100. At 16'h9999 → holds 16'h9999.
- **Jump clearance boundary.** `obstacle_valid`=1, `obstacle_x`=40:
  - `jump_phase`=56 → no hit.
  - `jump_phase`=57 → next cycle `game_status`=0, `game_over`=1.
  - Also `obstacle_x`=39 and 56 with `jump_phase`=63 → no hit; `obstacle_x`=55 → hit.
- **Hit collides with tick.** `score`=16'h0012, `div_cnt`=5, `tick` and `hit` in the same cycle → OVER, `score`=16'h0012, `high_score`=16'h0012 (was 0). A later game ending at 16'h0005 → `high_score` stays 16'h0012.
- **Lockout.** In OVER with `LOCKOUT`=30:
  - `start_edge` after 29 ticks → ignored.
  - `start_edge` coincident with the 30th tick → ignored.
  - `start_edge` after 30 ticks → RUNNING, `score`=0.
- **Reset mid-game.** `RST` asserted for one cycle in RUNNING with `score`=16'h0042 → next cycle IDLE, `score`=0, `high_score`=0, `game_status`=0.
